// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Brief    : Handshaked execute unit; single-cycle logic/arith ops plus an
//            iterative shift-add multiplier, registered result and flags.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             illegal
);

    localparam int                 c_cnt_w    = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
    localparam int                 c_msb      = WIDTH - 1;

    localparam logic [3:0] c_op_and   = 4'b0000;
    localparam logic [3:0] c_op_orr   = 4'b0001;
    localparam logic [3:0] c_op_add   = 4'b0010;
    localparam logic [3:0] c_op_sub   = 4'b0110;
    localparam logic [3:0] c_op_passb = 4'b0111;
    localparam logic [3:0] c_op_nor   = 4'b1100;
    localparam logic [3:0] c_op_mul   = 4'b1000;

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_MUL_BUSY = 1'b1
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [WIDTH-1:0]     r_acc;
    logic [c_cnt_w-1:0]   r_count;
    logic [WIDTH-1:0]     r_result;
    logic                 r_out_valid;
    logic                 r_carry;
    logic                 r_overflow;
    logic                 r_illegal;

    logic                 w_accept;
    logic                 w_is_mul;
    logic                 w_mul_done;
    logic                 w_load;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [WIDTH-1:0]     w_acc_next;
    logic [WIDTH-1:0]     w_res;
    logic                 w_carry;
    logic                 w_ovf;
    logic                 w_illegal;
    logic [WIDTH-1:0]     w_load_res;

    assign in_ready   = rst_n && (r_state == S_IDLE) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_is_mul   = (alu_ctrl == c_op_mul);
    assign w_sum      = {1'b0, op_a} + {1'b0, op_b};
    // Top bit of the widened difference is the borrow out.
    assign w_diff     = {1'b0, op_a} - {1'b0, op_b};
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mul_done = (r_state == S_MUL_BUSY) && (r_count == c_cnt_last);
    assign w_load     = (w_accept && !w_is_mul) || w_mul_done;
    assign w_load_res = w_mul_done ? w_acc_next : w_res;

    always_comb begin
        w_res     = '0;
        w_carry   = 1'b0;
        w_ovf     = 1'b0;
        w_illegal = 1'b0;
        case (alu_ctrl)
            c_op_and:   w_res = op_a & op_b;
            c_op_orr:   w_res = op_a | op_b;
            c_op_add: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (op_a[c_msb] == op_b[c_msb]) && (w_sum[c_msb] != op_a[c_msb]);
            end
            c_op_sub: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = !w_diff[WIDTH];
                w_ovf   = (op_a[c_msb] != op_b[c_msb]) && (w_diff[c_msb] != op_a[c_msb]);
            end
            c_op_passb: w_res = op_b;
            c_op_nor:   w_res = ~(op_a | op_b);
            c_op_mul:   w_res = '0;
            default:    w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_count     <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                if (w_accept && w_is_mul) begin
                    r_mcand  <= op_a;
                    r_mplier <= op_b;
                    r_acc    <= '0;
                    r_count  <= '0;
                    r_state  <= S_MUL_BUSY;
                end
            end else begin
                r_acc    <= w_acc_next;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_count  <= r_count + 1'b1;
                if (w_mul_done) begin
                    r_state <= S_IDLE;
                end
            end

            // Multiplier results carry no carry/overflow and are never illegal.
            if (w_load) begin
                r_result   <= w_load_res;
                r_carry    <= w_mul_done ? 1'b0 : w_carry;
                r_overflow <= w_mul_done ? 1'b0 : w_ovf;
                r_illegal  <= w_mul_done ? 1'b0 : w_illegal;
            end

            if (w_load) begin
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = (r_result == '0) && rst_n;
    assign negative  = r_result[c_msb];
    assign carry     = r_carry;
    assign overflow  = r_overflow;
    assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Brief    : Self-checking bench for alu_exec_unit with an expected-result queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    localparam int W = 64;
    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_ORR   = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MUL   = 4'b1000;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b1;
    logic [3:0]   alu_ctrl  = 4'b0000;
    logic [W-1:0] op_a      = '0;
    logic [W-1:0] op_b      = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic         zero, negative, carry, overflow, illegal;

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         n;
        logic         c;
        logic         v;
        logic         ill;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .negative  (negative),
        .carry     (carry),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t              e;
        logic [W:0]        s;
        logic signed [W+1:0] ws;
        logic [2*W-1:0]    p;
        e = '0;
        case (c)
            OP_AND:   e.res = a & b;
            OP_ORR:   e.res = a | b;
            OP_ADD: begin
                s     = {1'b0, a} + {1'b0, b};
                ws    = $signed({a[W-1], a}) + $signed({b[W-1], b});
                e.res = s[W-1:0];
                e.c   = s[W];
                e.v   = ws[W] ^ ws[W-1];
            end
            OP_SUB: begin
                ws    = $signed({a[W-1], a}) - $signed({b[W-1], b});
                e.res = a - b;
                e.c   = (a >= b);
                e.v   = ws[W] ^ ws[W-1];
            end
            OP_PASSB: e.res = b;
            OP_NOR:   e.res = ~(a | b);
            OP_MUL: begin
                p     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                e.res = p[W-1:0];
            end
            default:  e.ill = 1'b1;
        endcase
        e.z = (e.res == '0);
        e.n = e.res[W-1];
        return e;
    endfunction

    function automatic exp_t observe();
        return {result, zero, negative, carry, overflow, illegal};
    endfunction

    // Presents one op and holds it until the unit accepts it.
    task automatic send(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        bit done;
        done     = 1'b0;
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            #1;
            if (in_ready) begin
                @(posedge clk);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        #1;
        in_valid = 1'b0;
        if (done) begin
            q.push_back(model(c, a, b));
        end else begin
            checks++;
            errors++;
            $display("FAIL send_accept in_ready never rose for op %b", c);
        end
    endtask

    // Returns the first valid output and the edges elapsed after the accept edge.
    task automatic wait_out(output exp_t got, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 300);
        got = observe();
        lat = lat - 1;
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL wait_out out_valid absent after 300 cycles");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({observe(), out_valid, in_ready} !== '0) begin
            errors++;
            $display("FAIL reset_state got %h out_valid %b in_ready %b required all zero",
                     observe(), out_valid, in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        exp_t got, e;
        int   lat;
        @(negedge clk);
        send(OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        wait_out(got, lat);
        e = q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL add_ovf got %h required %h", got, e);
        end
        checks++;
        if (got.res !== 64'h8000_0000_0000_0000 || {got.z, got.n, got.c, got.v} !== 4'b0101) begin
            errors++;
            $display("FAIL add_ovf_const res %h zncv %b required 8000000000000000 0101",
                     got.res, {got.z, got.n, got.c, got.v});
        end
        checks++;
        if (lat !== 0) begin
            errors++;
            $display("FAIL add_latency got %0d required 0", lat);
        end
    endtask

    task automatic test_sub();
        exp_t         got, e;
        int           lat;
        logic [W-1:0] as [0:1];
        logic [W-1:0] bs [0:1];
        as[0] = 64'd5; bs[0] = 64'd5;
        as[1] = 64'd3; bs[1] = 64'd5;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            send(OP_SUB, as[i], bs[i]);
            wait_out(got, lat);
            e = q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL sub_%0d got %h required %h", i, got, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t         got, e;
        bit           rdy_ok;
        logic [3:0]   cs [0:2];
        logic [W-1:0] as [0:2];
        logic [W-1:0] bs [0:2];
        cs[0] = OP_AND; as[0] = 64'hF0; bs[0] = 64'h3C;
        cs[1] = OP_ORR; as[1] = 64'hF0; bs[1] = 64'h0F;
        cs[2] = OP_NOR; as[2] = 64'h0;  bs[2] = 64'h0;
        rdy_ok = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                alu_ctrl = cs[i];
                op_a     = as[i];
                op_b     = bs[i];
                in_valid = 1'b1;
                q.push_back(model(cs[i], as[i], bs[i]));
            end else begin
                in_valid = 1'b0;
            end
            if (i > 0) begin
                got = observe();
                e   = q.pop_front();
                checks++;
                if (!out_valid || got !== e) begin
                    errors++;
                    $display("FAIL b2b_%0d valid %b got %h required %h", i - 1, out_valid, got, e);
                end
            end
            if (i < 3 && !in_ready) rdy_ok = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (!rdy_ok) begin
            errors++;
            $display("FAIL b2b_in_ready dropped to 0 required 1 throughout");
        end
    endtask

    task automatic test_mul();
        exp_t got, e;
        int   n, lat;
        bit   busy_ready, extra;
        @(negedge clk);
        send(OP_MUL, 64'd12, 64'd11);
        // Changed operands and stray valid pulses while busy must be ignored.
        alu_ctrl   = OP_ADD;
        op_a       = 64'd100;
        op_b       = 64'd1;
        busy_ready = 1'b0;
        n          = 0;
        while (!out_valid && n < 300) begin
            in_valid = (n % 3 == 0) && (n < W - 4);
            @(negedge clk);
            n++;
            if (!out_valid && in_ready) busy_ready = 1'b1;
        end
        in_valid = 1'b0;
        got = observe();
        e   = q.pop_front();
        lat = n - 1;
        checks++;
        if (!out_valid || got !== e || got.res !== 64'd132) begin
            errors++;
            $display("FAIL mul_12x11 valid %b got %h required %h", out_valid, got, e);
        end
        checks++;
        if (lat !== W) begin
            errors++;
            $display("FAIL mul_latency got %0d required %0d", lat, W);
        end
        checks++;
        if (busy_ready) begin
            errors++;
            $display("FAIL mul_busy_in_ready got 1 required 0");
        end
        extra = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid) extra = 1'b1;
        end
        checks++;
        if (extra) begin
            errors++;
            $display("FAIL mul_busy_pulse_accepted out_valid 1 required 0");
        end

        send(OP_MUL, 64'h8000_0000_0000_0000, 64'd2);
        wait_out(got, lat);
        e = q.pop_front();
        checks++;
        if (got !== e || got.res !== '0 || !got.z) begin
            errors++;
            $display("FAIL mul_wrap got %h required %h", got, e);
        end
    endtask

    task automatic test_backpressure();
        exp_t got, e;
        bit   stable;
        @(negedge clk);
        out_ready = 1'b0;
        send(OP_ADD, 64'd1, 64'd2);
        e        = q.pop_front();
        alu_ctrl = OP_PASSB;
        op_a     = 64'd77;
        op_b     = 64'd9;
        in_valid = 1'b1;
        stable   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!out_valid || observe() !== e || e.res !== 64'd3 || in_ready) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL bp_hold result %h in_ready %b required %h and 0", result, in_ready, e.res);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        q.push_back(model(OP_PASSB, 64'd77, 64'd9));
        @(negedge clk);
        got = observe();
        e   = q.pop_front();
        checks++;
        if (!out_valid || got !== e) begin
            errors++;
            $display("FAIL bp_passb valid %b got %h required %h", out_valid, got, e);
        end
    endtask

    task automatic test_illegal();
        exp_t got, e;
        int   lat;
        @(negedge clk);
        send(4'b0101, 64'h1234, 64'h5678);
        wait_out(got, lat);
        e = q.pop_front();
        checks++;
        if (got !== e || !got.ill || !got.z || got.res !== '0) begin
            errors++;
            $display("FAIL illegal_code got %h required %h", got, e);
        end
    endtask

    task automatic test_reset_mid_mul();
        exp_t got, e;
        int   lat;
        bit   seen;
        @(negedge clk);
        send(OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        wait_out(got, lat);
        e = q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL pre_reset_add got %h required %h", got, e);
        end
        @(negedge clk);
        send(OP_MUL, 64'd3, 64'd5);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({observe(), out_valid, in_ready} !== '0) begin
            errors++;
            $display("FAIL reset_mid_mul got %h out_valid %b in_ready %b required all zero",
                     observe(), out_valid, in_ready);
        end
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_abort out_valid 1 required 0");
        end
        send(OP_ADD, 64'd1, 64'd1);
        wait_out(got, lat);
        e = q.pop_front();
        checks++;
        if (got !== e || got.res !== 64'd2) begin
            errors++;
            $display("FAIL post_reset_add got %h required %h", got, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_mul();
        test_backpressure();
        test_illegal();
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
